// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM states, the
// {hi,lo} payload type and a small magnitude helper.
package hilo_ctrl_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned HILO_W         = 64;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Two's-complement magnitude when en is set; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic en);
    return (en && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high), start (load operands), abort (drop
// the running division), dividend/divisor in; done pulses in the cycle of
// the final iteration, with quotient/remainder valid in that same cycle.
module div_iter
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_quo;

  // One restoring step: shift in the next dividend bit, try the subtract.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    step_rem = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};
  end

  // The final step's result is presented combinationally alongside done.
  assign quotient  = step_quo;
  assign remainder = step_rem;

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO write sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX.
// Ports: clk, rst (sync, active-high); start_valid_i/op_i/a_i/b_i describe
// the EX instruction, hilo_i is the current {hi,lo}; stall_i/flush_i come
// from the pipeline. stall_o freezes IF..EX, busy_o is state != IDLE, and
// hilo_we_o/hilo_wdata_o form the single HI/LO write port.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid_i,
  input  logic [2:0]          op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  input  logic [HILO_W-1:0]   hilo_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                hilo_we_o,
  output logic [HILO_W-1:0]   hilo_wdata_o
);

  state_e          state_q, state_d;
  hilo_t           result_q, result_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sgn_q, sgn_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  op_e             op_c;
  logic            accept_c;
  logic            kill_c;
  logic            div_signed_c;
  logic [HILO_W-1:0] mul_a_c, mul_b_c;

  logic            div_start, div_abort, div_done;
  logic [XLEN-1:0] div_dividend, div_divisor, div_quo, div_rem;

  assign op_c     = op_e'(op_i);
  assign kill_c   = rst | flush_i;
  assign accept_c = (state_q == ST_IDLE) & start_valid_i & ~stall_i & ~flush_i
                    & (op_c != OP_NONE);
  assign busy_o   = (state_q != ST_IDLE);

  // Divider sees magnitudes for DIV; signs are reapplied on completion.
  assign div_signed_c = (op_c == OP_DIV);
  assign div_dividend = mag(a_i, div_signed_c);
  assign div_divisor  = mag(b_i, div_signed_c);
  assign div_abort    = flush_i;

  // Operands extended to 64 bits so one multiplier covers both signednesses.
  assign mul_a_c = sgn_q ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign mul_b_c = sgn_q ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};

  div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next state and write-port control.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    a_d          = a_q;
    b_d          = b_q;
    sgn_d        = sgn_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    div_start    = 1'b0;
    stall_o      = 1'b0;
    hilo_we_o    = 1'b0;
    hilo_wdata_o = '0;

    if (kill_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            case (op_c)
              OP_MTHI: begin
                hilo_we_o    = 1'b1;
                hilo_wdata_o = {a_i, hilo_i[XLEN-1:0]};
              end
              OP_MTLO: begin
                hilo_we_o    = 1'b1;
                hilo_wdata_o = {hilo_i[HILO_W-1:XLEN], a_i};
              end
              OP_MULT, OP_MULTU: begin
                stall_o = 1'b1;
                a_d     = a_i;
                b_d     = b_i;
                sgn_d   = (op_c == OP_MULT);
                state_d = ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                stall_o = 1'b1;
                if (b_i == '0) begin
                  // Divide by zero bypasses the iteration entirely.
                  result_d = '{hi: a_i, lo: '1};
                  state_d  = ST_DONE;
                end else begin
                  div_start = 1'b1;
                  q_neg_d   = div_signed_c & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                  r_neg_d   = div_signed_c & a_i[XLEN-1];
                  state_d   = ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          stall_o  = 1'b1;
          result_d = hilo_t'(mul_a_c * mul_b_c);
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          stall_o = 1'b1;
          if (div_done) begin
            result_d.lo = q_neg_q ? (~div_quo + XLEN'(1)) : div_quo;
            result_d.hi = r_neg_q ? (~div_rem + XLEN'(1)) : div_rem;
            state_d     = ST_DONE;
          end
        end
        ST_DONE: begin
          hilo_we_o    = 1'b1;
          hilo_wdata_o = result_q;
          state_d      = stall_i ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          // Keeps the still-present EX instruction from being accepted again.
          if (!stall_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written sequences for
// flush, stall-in-DONE/HOLD, back-to-back and reset mid-operation.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [63:0] hilo_i;
  logic        stall_i, flush_i;
  logic        stall_o, busy_o, hilo_we_o;
  logic [63:0] hilo_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid_i(start_valid_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .hilo_i       (hilo_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .hilo_we_o    (hilo_we_o),
    .hilo_wdata_o (hilo_wdata_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hv;
    logic [63:0] exp_wd;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: results from plain integer arithmetic, latency from the op class.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hv, output logic [63:0] wd, output int lat);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wd = '0;
    lat = 0;
    case (op)
      OP_MULT:  begin wd = 64'(sa * sb); lat = 2; end
      OP_MULTU: begin wd = {32'b0, a} * {32'b0, b}; lat = 2; end
      OP_DIV: begin
        if (b == 0) begin wd = {a, 32'hFFFF_FFFF}; lat = 1; end
        else begin q = sa / sb; r = sa % sb; wd = {32'(r), 32'(q)}; lat = DIVC + 1; end
      end
      OP_DIVU: begin
        if (b == 0) begin wd = {a, 32'hFFFF_FFFF}; lat = 1; end
        else begin wd = {a % b, a / b}; lat = DIVC + 1; end
      end
      OP_MTHI: begin wd = {a, hv[31:0]}; lat = 0; end
      OP_MTLO: begin wd = {hv[63:32], a}; lat = 0; end
      default: ;
    endcase
  endfunction

  // Issue one op (held in EX while stalled), observe the write, then idle.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hv,
                        input logic [63:0] exp_wd, input int exp_lat);
    int stalls, wes, lat;
    logic [63:0] wd;
    logic extra;
    stalls = 0; wes = 0; lat = -1; wd = '0;
    start_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; hilo_i = hv;
    for (int c = 0; c <= DIVC + 8; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (hilo_we_o) begin wes++; wd = hilo_wdata_o; lat = c; end
      next_cycle();
      if (wes != 0) break;
    end
    start_valid_i = 1'b0; op_i = OP_NONE;
    @(negedge clk);
    extra = hilo_we_o | busy_o | stall_o;
    next_cycle();
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    chk({nm, " wdata"}, wd, exp_wd);
    chk({nm, " idle_after"}, 64'(extra), 64'(0));
  endtask

  initial begin
    int we_cnt;
    logic [63:0] ewd;
    int elat;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic [63:0] rh;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 2};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0, 64'h0000_0002_FFFF_FFFA, 2};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, DIVC + 1};
    vecs[3] = '{OP_DIVU,  32'd7,         32'd2, 64'h0, 64'h0000_0001_0000_0003, DIVC + 1};
    vecs[4] = '{OP_DIVU,  32'h1234,      32'd0, 64'h0, 64'h0000_1234_FFFF_FFFF, 1};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, DIVC + 1};
    vecs[6] = '{OP_MTHI,  32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222, 64'hDEAD_BEEF_2222_2222, 0};
    vecs[7] = '{OP_MTLO,  32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222, 64'h1111_1111_DEAD_BEEF, 0};
    vecs[8] = '{OP_DIV,   32'h1234,      32'd0, 64'h0, 64'h0000_1234_FFFF_FFFF, 1};
    vecs[9] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0, 64'h0000_0001_FFFF_FFFD, DIVC + 1};

    rst = 1'b1; start_valid_i = 1'b0; op_i = OP_NONE; a_i = '0; b_i = '0;
    hilo_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {hilo_wdata_o[60:0], stall_o, busy_o, hilo_we_o}, 64'h0);
    chk("reset_wdata_hi", 64'(hilo_wdata_o[63:61]), 64'h0);
    next_cycle();

    // Directed vectors.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hv,
             vecs[i].exp_wd, vecs[i].lat);

    // Flush a DIV at iteration 10: no write ever, then MULT works normally.
    we_cnt = 0;
    start_valid_i = 1'b1; op_i = OP_DIV; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
    @(negedge clk);
    chk("flush_div accept_stall", 64'(stall_o), 64'd1);
    if (hilo_we_o) we_cnt++;
    next_cycle();
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
      if (c == 5) chk("flush_div mid_stall", 64'({stall_o, busy_o}), 64'd3);
      next_cycle();
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_cycle outputs", 64'({stall_o, hilo_we_o}), 64'd0);
    next_cycle();
    flush_i = 1'b0; start_valid_i = 1'b0; op_i = OP_NONE;
    @(negedge clk);
    chk("flush_next idle", 64'(busy_o), 64'd0);
    next_cycle();
    for (int c = 0; c < DIVC + 4; c++) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
      next_cycle();
    end
    chk("flush_div no_write", 64'(we_cnt), 64'd0);
    run_op("after_flush_mult", OP_MULT, 32'd5, 32'hFFFF_FFFD, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1, 2);

    // MULT with stall_i in DONE: one pulse, HOLD persists, no re-accept.
    we_cnt = 0;
    start_valid_i = 1'b1; op_i = OP_MULT; a_i = 32'd6; b_i = 32'd7;
    for (int c = 0; c < 8; c++) begin
      stall_i = (c >= 2 && c <= 5);
      @(negedge clk);
      if (hilo_we_o) begin
        we_cnt++;
        chk("hold_mult wdata", hilo_wdata_o, 64'd42);
      end
      if (c == 4) chk("hold_state busy", 64'({busy_o, stall_o}), 64'b10);
      if (c == 6) chk("hold_release no_accept", 64'({stall_o, hilo_we_o}), 64'd0);
      next_cycle();
      if (c == 6) begin start_valid_i = 1'b0; op_i = OP_NONE; end
    end
    stall_i = 1'b0;
    chk("hold_mult we_pulses", 64'(we_cnt), 64'd1);
    chk("hold_end idle", 64'(busy_o), 64'd0);

    // Flush in DONE suppresses the write.
    start_valid_i = 1'b1; op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd3;
    next_cycle(); next_cycle();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_done suppress", 64'({hilo_we_o, stall_o}), 64'd0);
    next_cycle();
    flush_i = 1'b0; start_valid_i = 1'b0; op_i = OP_NONE;
    @(negedge clk);
    chk("flush_done idle", 64'(busy_o), 64'd0);
    next_cycle();

    // Flush and stall_i each block acceptance in IDLE.
    start_valid_i = 1'b1; op_i = OP_MTHI; a_i = 32'h5555_5555; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_blocks_mthi", 64'(hilo_we_o), 64'd0);
    next_cycle();
    op_i = OP_MULT; stall_i = 1'b1; flush_i = 1'b0;
    @(negedge clk);
    chk("stall_blocks_accept", 64'(stall_o), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("stall_blocks_busy", 64'(busy_o), 64'd0);
    next_cycle();
    stall_i = 1'b0;

    // Back-to-back: MTLO accepted in the cycle right after DONE.
    op_i = OP_MULT; a_i = 32'd2; b_i = 32'd2; hilo_i = 64'hAAAA_AAAA_BBBB_BBBB;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("b2b first_write", 64'(hilo_we_o), 64'd1);
    next_cycle();
    op_i = OP_MTLO; a_i = 32'h0BAD_F00D;
    @(negedge clk);
    chk("b2b second_write", {63'b0, hilo_we_o} == 64'd1 ? hilo_wdata_o : 64'hX, 64'hAAAA_AAAA_0BAD_F00D);
    next_cycle();
    start_valid_i = 1'b0; op_i = OP_NONE;

    // Reset mid-DIV returns to idle with quiet outputs.
    start_valid_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    repeat (5) next_cycle();
    rst = 1'b1; start_valid_i = 1'b0; op_i = OP_NONE;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_op", {hilo_wdata_o[60:0], stall_o, busy_o, hilo_we_o}, 64'h0);
    next_cycle();
    for (int c = 0; c < DIVC + 4; c++) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
      next_cycle();
    end
    chk("reset_mid_op no_write", 64'(we_cnt), 64'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rh = {$urandom, $urandom};
      model(rop, ra, rb, rh, ewd, elat);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rh, ewd, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
